// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: converts the core's SRAM-like instruction port (read-only)
// and data port (read/write) into one AXI3 master. The bridge keeps at most one
// read and one write outstanding. Fixed AXI fields such as len, burst, lock,
// cache, prot, awid, wid and wlast are tied off at the SoC top.
//
// Ports:
//   clk, resetn          clock; asynchronous active-low reset
//   inst_*               instruction request, handshake and read data
//   data_*               data request (rd/wr, size, strobes), handshake and read data
//   ar*/r*               AXI read address and read data channels
//   aw*/w*/b*            AXI write address, write data and write response channels
//
// Build option: BRIDGE_RAW_CHECK_EN. When it is defined, a data read stalls only
// while the outstanding write targets the same word. When it is undefined, a data
// read stalls whenever any write is in flight.
module sram_axi_bridge #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;
    typedef enum logic [1:0] {WIdle, WSend, WResp} w_state_e;

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [2:0]  awsize_q, awsize_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic raw_block;
    logic rd_data_pending;
    logic data_rd_ok, data_wr_ok, inst_ok;
    logic r_hold;

`ifdef BRIDGE_RAW_CHECK_EN
    assign raw_block = (w_state_q != WIdle) && (awaddr_q[31:2] == data_addr[31:2]);
    // A data read may overtake an in-flight write. Its R beat is held off until
    // the write's B response has gone back, so data_data_ok stays in request order.
    assign r_hold    = (rid == ID_DATA) && (w_state_q != WIdle);
`else
    assign raw_block = (w_state_q != WIdle);
    assign r_hold    = 1'b0;
`endif

    // An outstanding data read blocks new writes, so data completions return in order.
    assign rd_data_pending = (r_state_q != RIdle) && (arid_q == ID_DATA);

    assign data_rd_ok = (r_state_q == RIdle) && data_req && !data_wr && !raw_block;
    assign data_wr_ok = (w_state_q == WIdle) && data_req && data_wr && !rd_data_pending;
    // Instruction fetch takes the read channel only if no data read wins it this cycle.
    assign inst_ok    = (r_state_q == RIdle) && inst_req && !data_rd_ok;

    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        unique case (r_state_q)
            RIdle: begin
                if (data_rd_ok) begin
                    arid_d    = ID_DATA;
                    araddr_d  = data_addr;
                    arsize_d  = {1'b0, data_size};
                    r_state_d = RAddr;
                end else if (inst_ok) begin
                    arid_d    = ID_INST;
                    araddr_d  = inst_addr;
                    arsize_d  = 3'd2;
                    r_state_d = RAddr;
                end
            end
            RAddr:   if (arready) r_state_d = RData;
            RData:   if (rvalid && !r_hold) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        awsize_d  = awsize_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (w_state_q)
            WIdle: begin
                if (data_wr_ok) begin
                    awaddr_d  = data_addr;
                    awsize_d  = {1'b0, data_size};
                    wdata_d   = data_wdata;
                    wstrb_d   = data_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = WSend;
                end
            end
            WSend: begin
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) w_state_d = WResp;
            end
            WResp:   if (bvalid) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= RIdle;
            w_state_q <= WIdle;
            arid_q    <= 4'd0;
            araddr_q  <= 32'd0;
            arsize_q  <= 3'd0;
            awaddr_q  <= 32'd0;
            awsize_q  <= 3'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            awaddr_q  <= awaddr_d;
            awsize_q  <= awsize_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign inst_addr_ok = inst_ok;
    assign data_addr_ok = data_rd_ok | data_wr_ok;

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arsize  = arsize_q;
    assign arvalid = (r_state_q == RAddr);
    assign rready  = (r_state_q == RData) && !r_hold;

    assign awaddr  = awaddr_q;
    assign awsize  = awsize_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign awvalid = (w_state_q == WSend) && !aw_done_q;
    assign wvalid  = (w_state_q == WSend) && !w_done_q;
    assign bready  = (w_state_q == WResp);

    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign inst_data_ok = rvalid && rready && (rid == ID_INST);
    assign data_data_ok = (rvalid && rready && (rid == ID_DATA)) || (bvalid && bready);

endmodule
